key_poll_master: RTL and testbench
==================================

KEY_POLL_MASTER -- requirements
Module: key_poll_master

Interface
REQ-001 SHALL have parameter POLL_DIV, default 50000, clock cycles between poll read requests (minimum 4).
REQ-002 SHALL have parameter DEBOUNCE_N, default 4, consecutive identical samples needed to accept a key level change (1..15).
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles a read may stall on waitrequest.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have port enable, input, 1, polling enable; 0 parks the FSM in IDLE after any read in flight completes.
REQ-007 SHALL have port avm_address, output, 2, Avalon-MM read address, constant 0.
REQ-008 SHALL have port avm_read, output, 1, Avalon-MM read request.
REQ-009 SHALL have port avm_waitrequest, input, 1, slave stall; tie 0 for the key PIO.
REQ-010 SHALL have port avm_readdata, input, 32, read data, valid exactly 1 cycle after acceptance.
REQ-011 SHALL have port keys_db, output, 2, debounced key levels, active-low (0 = pressed).
REQ-012 SHALL have port press_evt, output, 2, one-cycle pulse per bit on a debounced 1->0 transition.
REQ-013 SHALL have port release_evt, output, 2, one-cycle pulse per bit on a debounced 0->1 transition.
REQ-014 SHALL have port bus_err, output, 1, sticky flag set on read timeout.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, RESP.
REQ-016 In IDLE, SHALL decrement a poll timer each cycle while enable=1; at 0, SHALL reload POLL_DIV-1 and enter REQ.
REQ-017 In REQ, SHALL drive avm_read=1 and avm_address=0, holding them until avm_waitrequest=0 (acceptance), then enter RESP.
REQ-018 In RESP, SHALL sample avm_readdata[1:0] into the debouncer and return to IDLE; bits [31:2] SHALL be ignored.
REQ-019 avm_read SHALL be 1 only in REQ; exactly one request per poll, never back-to-back.
REQ-020 If REQ lasts TIMEOUT cycles without acceptance, SHALL deassert avm_read, set bus_err, discard the sample, and return to IDLE.
REQ-021 bus_err SHALL clear only on reset.
REQ-022 Per bit, SHALL keep a 4-bit match counter: sample != keys_db increments it; sample == keys_db clears it.
REQ-023 When the counter reaches DEBOUNCE_N, SHALL update keys_db on the next edge, clear the counter, and pulse press_evt or release_evt in the same cycle as the keys_db change.
REQ-024 Bits SHALL debounce independently; simultaneous events on both bits SHALL both pulse in the same cycle.
REQ-025 The counter SHALL saturate and never wrap.
REQ-026 enable falling while in REQ or RESP SHALL complete the current read; the poll timer SHALL freeze while enable=0 and resume from its held value.
REQ-027 Event latency: keys_db changes 1 cycle after the RESP cycle of the DEBOUNCE_N-th consistent sample.

Reset
REQ-028 While reset_n=0 at a clock edge: FSM->IDLE, poll timer->POLL_DIV-1, avm_read=0, avm_address=0, keys_db=2'b11, press_evt=release_evt=0, counters=0, bus_err=0.
REQ-029 Reset asserted mid-read SHALL drop avm_read on the next edge; the late readdata SHALL be ignored.

Structure
REQ-030 Package key_poll_pkg SHALL hold the FSM state enum and the counter width constant.
REQ-031 Per-bit debounce SHALL be sub-module key_debounce (sample, sample_valid -> level, press, release), instantiated twice.

Verification
REQ-032 POLL_DIV=8, waitrequest=0: avm_read pulses 1 cycle, period 10 cycles; address always 0.
REQ-033 DEBOUNCE_N=4, readdata 0x1 held: press_evt=2'b10 once after 4th RESP; keys_db=2'b01.
REQ-034 Bounce 0x3,0x1,0x3,0x1,0x1,0x1,0x1: exactly one press_evt[1], after the last sample.
REQ-035 waitrequest=1 for 3 cycles: avm_read held 4 cycles, data sampled the cycle after acceptance.
REQ-036 TIMEOUT=5, waitrequest stuck 1: avm_read drops after 5 cycles, bus_err=1, keys_db unchanged.
REQ-037 reset_n=0 in REQ: avm_read=0 next edge, all outputs at reset values.

Source files
------------

// File: rtl/key_poll_pkg.sv
// Shared types and constants for the key-poll Avalon-MM master.
// Holds the FSM state encoding and the debounce counter width.
package key_poll_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W    = 4;
  localparam int NUM_KEYS = 2;
endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: accepts a level change after DEBOUNCE_N consecutive
// differing samples, then pulses press/release alongside the level update.
module key_debounce
  import key_poll_pkg::*;
#(
  parameter int DEBOUNCE_N = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample,
  input  logic sample_valid,
  output logic level,
  output logic press_evt,
  output logic release_evt
);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(DEBOUNCE_N);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt;

  // The counter hitting the threshold commits on the following edge, so the
  // level flip and its event pulse appear in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level       <= 1'b1;
      cnt         <= '0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
    end else begin
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      if (cnt == CNT_HIT) begin
        level       <= ~level;
        cnt         <= '0;
        press_evt   <= level;
        release_evt <= ~level;
      end else if (sample_valid) begin
        if (sample == level)
          cnt <= '0;
        else if (cnt != CNT_MAX)
          cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/key_poll_master.sv
// Avalon-MM master that periodically reads the key PIO, with read timeout
// detection and per-key debouncing of the sampled levels.
module key_poll_master
  import key_poll_pkg::*;
#(
  parameter int POLL_DIV   = 50000,
  parameter int DEBOUNCE_N = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  output logic [1:0]          avm_address,
  output logic                avm_read,
  input  logic                avm_waitrequest,
  input  logic [31:0]         avm_readdata,
  output logic [NUM_KEYS-1:0] keys_db,
  output logic [NUM_KEYS-1:0] press_evt,
  output logic [NUM_KEYS-1:0] release_evt,
  output logic                bus_err
);
  localparam int TMR_W = $clog2(POLL_DIV);
  localparam int WT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_DIV - 1);
  localparam logic [WT_W-1:0]  WT_LAST    = WT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [WT_W-1:0]  wcnt, wcnt_nxt;
  logic             err_nxt;
  logic             sample_valid;
  logic             unused_rd;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      tmr     <= TMR_RELOAD;
      wcnt    <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      wcnt    <= wcnt_nxt;
      bus_err <= err_nxt;
    end
  end

  // Timer only moves in IDLE with enable high; REQ/RESP always run to
  // completion so a disable never strands a bus transaction.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    wcnt_nxt  = wcnt;
    err_nxt   = bus_err;
    case (state)
      IDLE: begin
        if (enable) begin
          if (tmr == '0) begin
            tmr_nxt   = TMR_RELOAD;
            wcnt_nxt  = '0;
            state_nxt = REQ;
          end else begin
            tmr_nxt = tmr - 1'b1;
          end
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          state_nxt = RESP;
        end else if (wcnt == WT_LAST) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign avm_read     = (state == REQ);
  assign avm_address  = 2'b00;
  assign sample_valid = (state == RESP);
  assign unused_rd    = ^avm_readdata[31:NUM_KEYS];

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_db (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample       (avm_readdata[i]),
      .sample_valid (sample_valid),
      .level        (keys_db[i]),
      .press_evt    (press_evt[i]),
      .release_evt  (release_evt[i])
    );
  end
endmodule

// File: tb/tb_key_poll_master.sv
// Directed bench for key_poll_master (POLL_DIV=8, DEBOUNCE_N=4, TIMEOUT=5):
// poll period, debounce latency/events, wait states, timeout, enable, reset.
module tb_key_poll_master;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [1:0]  keys_db;
  logic [1:0]  press_evt;
  logic [1:0]  release_evt;
  logic        bus_err;

  int n_assert = 0;
  int n_fail   = 0;
  int n_press1 = 0;

  key_poll_master #(.POLL_DIV(8), .DEBOUNCE_N(4), .TIMEOUT(5)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .keys_db         (keys_db),
    .press_evt       (press_evt),
    .release_evt     (release_evt),
    .bus_err         (bus_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (press_evt[1] === 1'b1) n_press1++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until avm_read is seen (bounded); n = ticks taken.
  task automatic wait_read(output int n);
    n = 0;
    while (avm_read !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("wait_read_seen", {31'd0, avm_read}, 32'd1);
    chk("read_address", {30'd0, avm_address}, 32'd0);
  endtask

  // One poll with ws wait states; readdata is junk (~v) except in the RESP
  // cycle. Returns in the cycle after RESP.
  task automatic poll_ws(input logic [1:0] v, input int ws);
    int n;
    avm_readdata    = {30'd0, ~v};
    avm_waitrequest = (ws != 0);
    wait_read(n);
    for (int k = 0; k < ws; k++) begin
      tick();
      chk("ws_read_held", {31'd0, avm_read}, 32'd1);
    end
    avm_waitrequest = 1'b0;
    tick();
    avm_readdata = {30'h2aaaaaaa, v};
    chk("resp_read_low", {31'd0, avm_read}, 32'd0);
    tick();
    avm_readdata = {30'd0, ~v};
  endtask

  // Four consistent polls, then check latency and the event pulse.
  task automatic poll4(input logic [1:0] v, input int ws, input logic [1:0] k_old,
                       input logic [1:0] k_new, input logic [1:0] p, input logic [1:0] r);
    for (int i = 0; i < 4; i++) poll_ws(v, ws);
    chk("lat_keys_old", {30'd0, keys_db}, {30'd0, k_old});
    chk("lat_press_0", {30'd0, press_evt}, 32'd0);
    tick();
    chk("keys_new", {30'd0, keys_db}, {30'd0, k_new});
    chk("press_evt", {30'd0, press_evt}, {30'd0, p});
    chk("release_evt", {30'd0, release_evt}, {30'd0, r});
    tick();
    chk("evt_one_cycle", {28'd0, press_evt, release_evt}, 32'd0);
  endtask

  initial begin : main
    int n;
    int p_before;
    int reads;
    logic [1:0] bvals [7];
    bvals = '{2'd3, 2'd1, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1};

    reset_n = 1'b0; enable = 1'b0; avm_waitrequest = 1'b0; avm_readdata = 32'd3;
    tick(); tick();
    chk("rst_read", {31'd0, avm_read}, 32'd0);
    chk("rst_addr", {30'd0, avm_address}, 32'd0);
    chk("rst_keys", {30'd0, keys_db}, 32'd3);
    chk("rst_evts", {28'd0, press_evt, release_evt}, 32'd0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);

    // Poll period: first read 8 ticks after reset, one-cycle pulse, period 10.
    reset_n = 1'b1; enable = 1'b1;
    wait_read(n);
    chk("first_read_ticks", n, 8);
    tick();
    chk("read_pulse_1cyc", {31'd0, avm_read}, 32'd0);
    wait_read(n);
    chk("poll_period", n + 1, 10);
    tick(); tick();

    // Key 1 pressed (0x1): press_evt=10, keys_db=01.
    poll4(2'b01, 0, 2'b11, 2'b01, 2'b10, 2'b00);
    // Both bits change together (0x2): press bit0, release bit1.
    poll4(2'b10, 0, 2'b01, 2'b10, 2'b01, 2'b10);
    // Three wait states; only the post-acceptance data may count.
    poll4(2'b11, 3, 2'b10, 2'b11, 2'b00, 2'b01);

    // Bounce: exactly one press on bit 1, after the last sample.
    p_before = n_press1;
    for (int i = 0; i < 7; i++) begin
      poll_ws(bvals[i], 0);
      if (i == 5) chk("bounce_hold", {30'd0, keys_db}, 32'd3);
    end
    chk("bounce_lat", {30'd0, keys_db}, 32'd3);
    tick();
    chk("bounce_keys", {30'd0, keys_db}, 32'd1);
    chk("bounce_press", {30'd0, press_evt}, 32'd2);
    tick();
    chk("bounce_one_press", n_press1 - p_before, 1);

    // Timeout: waitrequest stuck, read held 5 cycles then dropped.
    avm_waitrequest = 1'b1;
    avm_readdata = 32'd3;
    wait_read(n);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("to_read_held", {31'd0, avm_read}, 32'd1);
      chk("to_err_not_yet", {31'd0, bus_err}, 32'd0);
    end
    tick();
    chk("to_read_drop", {31'd0, avm_read}, 32'd0);
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    enable = 1'b0;
    avm_waitrequest = 1'b0;

    // Disabled: no reads; timer resumes from its held value.
    reads = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (avm_read === 1'b1) reads++;
    end
    chk("disabled_no_read", reads, 0);
    chk("to_keys_unchanged", {30'd0, keys_db}, 32'd1);
    enable = 1'b1;
    wait_read(n);
    chk("resume_ticks", n, 8);
    chk("err_sticky", {31'd0, bus_err}, 32'd1);

    // Reset during REQ.
    reset_n = 1'b0;
    tick();
    chk("midrst_read", {31'd0, avm_read}, 32'd0);
    chk("midrst_keys", {30'd0, keys_db}, 32'd3);
    chk("midrst_err", {31'd0, bus_err}, 32'd0);
    chk("midrst_evts", {28'd0, press_evt, release_evt}, 32'd0);
    chk("midrst_addr", {30'd0, avm_address}, 32'd0);
    reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
